// File: rtl/wm_cycle_ctrl.sv
// Washing-machine program sequencer: 0.5 s time base, phase timing, actuator
// enables with pause/door interlock, and the blink inputs for the status LED.
module wm_cycle_ctrl #(
  parameter int HALF_SEC_CYCLES = 62500000,
  parameter int FILL_T          = 20,
  parameter int WASH_T          = 60,
  parameter int RINSE_T         = 40,
  parameter int SPIN_T          = 30,
  parameter int DONE_T          = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       door_closed,
  output logic       tick_0p5s,
  output logic       led_en,
  output logic [7:0] blink_cnt,
  output logic [2:0] phase,
  output logic       valve_on,
  output logic       motor_on,
  output logic       spin_on,
  output logic       busy,
  output logic       paused
);

  localparam int            PW      = (HALF_SEC_CYCLES > 2) ? $clog2(HALF_SEC_CYCLES) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(HALF_SEC_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4,
    DONE  = 3'd5
  } phase_e;

  phase_e        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [7:0]    rem, rem_n;
  logic          blink, blink_n;
  logic          hold, run, hold_n;

  function automatic logic is_busy(input phase_e p);
    return (p == FILL) || (p == WASH) || (p == RINSE) || (p == SPIN);
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      FILL:    return WASH;
      WASH:    return RINSE;
      RINSE:   return SPIN;
      SPIN:    return DONE;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [7:0] duration(input phase_e p);
    case (p)
      FILL:    return 8'(FILL_T);
      WASH:    return 8'(WASH_T);
      RINSE:   return 8'(RINSE_T);
      SPIN:    return 8'(SPIN_T);
      DONE:    return 8'(DONE_T);
      default: return 8'd0;
    endcase
  endfunction

  // Priority: stop > tick advance > start. DONE is never held.
  always_comb begin
    hold      = is_busy(state) & (pause | ~door_closed);
    run       = (state != IDLE) & ~hold;
    tick_0p5s = run & (presc == PS_LAST);
    state_n   = state;
    presc_n   = presc;
    rem_n     = rem;
    blink_n   = blink;
    if (stop) begin
      state_n = IDLE;
      presc_n = '0;
      rem_n   = 8'd0;
      blink_n = 1'b0;
    end else if (tick_0p5s) begin
      presc_n = '0;
      blink_n = ~blink;
      if (rem == 8'd1) begin
        state_n = next_phase(state);
        rem_n   = duration(next_phase(state));
        if (next_phase(state) == IDLE) blink_n = 1'b0;
      end else begin
        rem_n = rem - 8'd1;
      end
    end else if (run) begin
      presc_n = presc + PW'(1);
    end else if ((state == IDLE) && start && door_closed) begin
      state_n = FILL;
      presc_n = '0;
      rem_n   = duration(FILL);
      blink_n = 1'b0;
    end
    hold_n = is_busy(state_n) & (pause | ~door_closed);
  end

  // Actuator and status outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      rem      <= 8'd0;
      blink    <= 1'b0;
      valve_on <= 1'b0;
      motor_on <= 1'b0;
      spin_on  <= 1'b0;
      busy     <= 1'b0;
      paused   <= 1'b0;
      led_en   <= 1'b0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      rem      <= rem_n;
      blink    <= blink_n;
      valve_on <= ((state_n == FILL) || (state_n == RINSE)) && !hold_n;
      motor_on <= ((state_n == WASH) || (state_n == RINSE)) && !hold_n;
      spin_on  <= (state_n == SPIN) && !hold_n;
      busy     <= is_busy(state_n);
      paused   <= is_busy(state_n) && hold_n;
      led_en   <= (state_n != IDLE);
    end
  end

  assign phase     = state;
  assign blink_cnt = {7'd0, blink};

endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// Directed bench for wm_cycle_ctrl with a 4-cycle tick and short phase durations.
module tb_wm_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, pause, stop, door_closed;
  logic       tick_0p5s, led_en, valve_on, motor_on, spin_on, busy, paused;
  logic [7:0] blink_cnt;
  logic [2:0] phase;
  int         checks = 0;
  int         errors = 0;
  int         cnt;

  always #5 clk = ~clk;

  wm_cycle_ctrl #(
    .HALF_SEC_CYCLES(4), .FILL_T(2), .WASH_T(3), .RINSE_T(2), .SPIN_T(2), .DONE_T(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .door_closed(door_closed), .tick_0p5s(tick_0p5s), .led_en(led_en),
    .blink_cnt(blink_cnt), .phase(phase), .valve_on(valve_on),
    .motor_on(motor_on), .spin_on(spin_on), .busy(busy), .paused(paused)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // State s counts cycles after the start edge; FILL 1..8, WASH 9..20,
  // RINSE 21..28, SPIN 29..36, DONE 37..44.
  function automatic int exp_phase(input int s);
    if (s < 1)   return 0;
    if (s <= 8)  return 1;
    if (s <= 20) return 2;
    if (s <= 28) return 3;
    if (s <= 36) return 4;
    if (s <= 44) return 5;
    return 0;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic full_run(input bit inject);
    int ticks;
    int ep;
    ticks = 0;
    pulse_start();
    for (int s = 1; s <= 44; s++) begin
      if (inject && (s == 3 || s == 40)) start = 1'b1;
      #1;
      ep = exp_phase(s);
      if (tick_0p5s) ticks++;
      chk("run_phase", phase, ep);
      chk("run_tick", tick_0p5s, (s % 4) == 0);
      chk("run_blink", blink_cnt, ((s - 1) / 4) % 2);
      chk("run_valve", valve_on, (ep == 1) || (ep == 3));
      chk("run_motor", motor_on, (ep == 2) || (ep == 3));
      chk("run_spin", spin_on, ep == 4);
      chk("run_busy", busy, (ep >= 1) && (ep <= 4));
      chk("run_led", led_en, 1);
      chk("run_paused", paused, 0);
      step();
      start = 1'b0;
    end
    chk("end_phase", phase, 0);
    chk("end_led", led_en, 0);
    chk("end_busy", busy, 0);
    chk("tick_count", ticks, 11);
  endtask

  // Starts on the entry cycle of phase ph; holds on relative cycles hf..ht.
  task automatic run_hold(input int ph, input int hf, input int ht, input bit use_door,
                          input int exp_blink, input int exp_len);
    int j;
    j = 0;
    while (phase == 3'(ph) && j < 100) begin
      if (use_door) door_closed = !(j >= hf && j <= ht);
      else          pause       = (j >= hf && j <= ht);
      #1;
      if (j >= hf && j <= ht) chk("hold_tick", tick_0p5s, 0);
      if (j >= hf && j <= ht + 1) chk("hold_blink", blink_cnt, exp_blink);
      if (j >= hf + 1 && j <= ht + 1) begin
        chk("hold_paused", paused, 1);
        chk("hold_valve", valve_on, 0);
        chk("hold_motor", motor_on, 0);
        chk("hold_spin", spin_on, 0);
        chk("hold_led", led_en, 1);
        chk("hold_busy", busy, 1);
      end
      if (j == ht + 2) begin
        chk("resume_paused", paused, 0);
        chk("resume_valve", valve_on, (ph == 1) || (ph == 3));
        chk("resume_motor", motor_on, (ph == 2) || (ph == 3));
        chk("resume_spin", spin_on, ph == 4);
      end
      step();
      j++;
    end
    pause       = 1'b0;
    door_closed = 1'b1;
    chk("hold_len", j, exp_len);
  endtask

  task automatic wait_idle();
    int j;
    j = 0;
    while (phase != 3'd0 && j < 100) begin
      step();
      j++;
    end
    chk("reach_idle", phase, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_valve"}, valve_on, 0);
    chk({tag, "_motor"}, motor_on, 0);
    chk({tag, "_spin"}, spin_on, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_paused"}, paused, 0);
    chk({tag, "_led"}, led_en, 0);
    chk({tag, "_blink"}, blink_cnt, 0);
    chk({tag, "_tick"}, tick_0p5s, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; door_closed = 1'b1;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;

    full_run(1'b0);
    step();
    full_run(1'b1);
    step();

    // Pause for 10 cycles mid-WASH stretches WASH from 12 to 22 cycles.
    pulse_start();
    repeat (8) step();
    chk("pause_entry", phase, 2);
    run_hold(2, 1, 10, 1'b0, 0, 22);
    wait_idle();

    // Start with the door open is dropped.
    door_closed = 1'b0;
    pulse_start();
    door_closed = 1'b1;
    #1;
    chk("door_start_phase", phase, 0);
    chk("door_start_led", led_en, 0);
    step();
    chk("door_start_later", phase, 0);

    // Door opens for 5 cycles in SPIN.
    pulse_start();
    repeat (28) step();
    chk("spin_entry", phase, 4);
    run_hold(4, 1, 5, 1'b1, 1, 13);
    wait_idle();

    // Stop in RINSE.
    pulse_start();
    repeat (21) step();
    chk("stop_entry", phase, 3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_all_zero("stop");
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk("stop_start_phase", phase, 0);
    chk("stop_start_led", led_en, 0);
    step();
    chk("stop_start_later", phase, 0);

    // Reset mid-WASH with a start presented during reset.
    pulse_start();
    repeat (11) step();
    chk("rst_entry", phase, 2);
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk_all_zero("midrst");
    step();
    chk("rst_start_ignored", phase, 0);
    pulse_start();
    cnt = 0;
    while (phase != 3'd0 && cnt < 100) begin
      cnt++;
      step();
    end
    chk("fresh_run_len", cnt, 44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
